adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Two requesters share one 4-bit ripple-carry adder through an IDLE/CALC/RESP FSM.
// Optional signed-overflow output is built only when ADDER_ARB_OVF_EN is defined.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       cin0,
  input  logic       cin1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] s,
  output logic       co,
  output logic       sel,
  output logic       busy,
  output logic       ovf,
  output logic [1:0] state_dbg
);

  // Handshake: a requester holds req high with stable operands until its ack;
  // ack is a single-cycle pulse in RESP and s/co/sel are valid while it is high.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       sel_q, sel_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       op_c_q, op_c_d;
  logic [3:0] s_q, s_d;
  logic       co_q, co_d;
  logic       grant1;
  logic [3:0] sum;
  logic [4:0] carry;

  assign carry[0] = op_c_q;

  for (genvar i = 0; i < 4; i++) begin : g_rca
    full_adder u_fa (
      .a  (op_a_q[i]),
      .b  (op_b_q[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // A lone request always wins; ties go to the pointer unless fixed priority.
  always_comb begin
    grant1 = req1;
    if (req0 && req1) begin
      grant1 = FIXED_PRI ? 1'b0 : ptr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_c_d  = op_c_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = CALC;
          sel_d   = grant1;
          op_a_d  = grant1 ? a1 : a0;
          op_b_d  = grant1 ? b1 : b0;
          op_c_d  = grant1 ? cin1 : cin0;
        end
      end
      CALC: begin
        state_d = RESP;
        s_d     = sum;
        co_d    = carry[4];
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = ~sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      op_a_q  <= 4'd0;
      op_b_q  <= 4'd0;
      op_c_q  <= 1'b0;
      s_q     <= 4'd0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_c_q  <= op_c_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == CALC) begin
      ovf_d = (op_a_q[3] == op_b_q[3]) && (sum[3] != op_a_q[3]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ack0      = (state_q == RESP) && !sel_q;
  assign ack1      = (state_q == RESP) && sel_q;
  assign s         = s_q;
  assign co        = co_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
